// File: rtl/qlm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qlm_pkg
// Brief    : Shared constants, width helpers and log-word type for the
//            pipelined quantised log multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package qlm_pkg;

    localparam int W_DEF     = 16;
    localparam int Q_DEF     = 5;
    localparam int MIN_K_DEF = 5;
    localparam int TAG_W_DEF = 4;

    // Width needed for a characteristic of a 2W-bit product (0 .. 2W-1).
    function automatic int kw_of(input int w);
        return $clog2(2 * w);
    endfunction

    localparam int KW_DEF = $clog2(2 * W_DEF);

    // Log-domain word: integer characteristic above a Q-bit fraction.
    typedef struct packed {
        logic [KW_DEF-1:0] k;
        logic [Q_DEF-1:0]  f;
    } qlm_log_t;

endpackage : qlm_pkg
`default_nettype wire

// File: rtl/qlm_lod_frac.sv
`default_nettype none
// ============================================================================
// Module   : qlm_lod_frac
// Brief    : Combinational leading-one detector with truncated fraction
//            extraction. Leading ones below MIN_K are reported as zero.
// Revision : 1.0 - initial release
// ============================================================================
module qlm_lod_frac
    import qlm_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int Q     = Q_DEF,
    parameter int MIN_K = MIN_K_DEF,
    parameter int KW    = kw_of(W)
) (
    input  logic [W-1:0]  i_mag,
    output logic [KW-1:0] o_k,
    output logic [Q-1:0]  o_frac,
    output logic          o_zero
);

    logic [KW-1:0] w_k;
    logic          w_zero;
    logic [Q-1:0]  w_frac;

    // Scan upward so the highest set bit in [MIN_K, W-1] wins; then take the
    // Q bits just below it. Q <= MIN_K keeps the slice inside the operand.
    always_comb begin
        w_k    = '0;
        w_zero = 1'b1;
        for (int i = MIN_K; i < W; i++) begin
            if (i_mag[i]) begin
                w_k    = KW'(i);
                w_zero = 1'b0;
            end
        end
        if (w_zero) begin
            w_frac = '0;
        end else begin
            w_frac = Q'(i_mag >> (w_k - KW'(Q)));
        end
    end

    assign o_k    = w_k;
    assign o_frac = w_frac;
    assign o_zero = w_zero;

endmodule : qlm_lod_frac
`default_nettype wire

// File: rtl/qlm_pipe_mult.sv
`default_nettype none
// ============================================================================
// Module   : qlm_pipe_mult
// Brief    : Three-stage pipelined Mitchell-style approximate multiplier with
//            valid/ready flow control, signed/unsigned mode and a sideband tag.
//            S1 conditions operands, S2 adds in the log domain, S3 applies the
//            shift-based antilog and sign and drives the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module qlm_pipe_mult
    import qlm_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int Q     = Q_DEF,
    parameter int MIN_K = MIN_K_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_p,
    output logic [TAG_W-1:0] out_tag
);

    localparam int KW = kw_of(W);
    localparam int LW = KW + Q;
    localparam int PW = 2 * W;

    // ------------------------------------------------------------------
    // Stage enables and S1 operand conditioning
    // ------------------------------------------------------------------
    logic w_en1, w_en2, w_en3;
    logic w_sx, w_sy;
    logic [W-1:0]  w_ax, w_ay;
    logic [KW-1:0] w_kx, w_ky;
    logic [Q-1:0]  w_fx, w_fy;
    logic          w_zx, w_zy;

    // Pipeline registers (S1, S2, S3)
    logic             r_v1_q, w_v1_d;
    logic [KW-1:0]    r_kx1_q, w_kx1_d, r_ky1_q, w_ky1_d;
    logic [Q-1:0]     r_fx1_q, w_fx1_d, r_fy1_q, w_fy1_d;
    logic             r_zx1_q, w_zx1_d, r_zy1_q, w_zy1_d;
    logic             r_sign1_q, w_sign1_d;
    logic [TAG_W-1:0] r_tag1_q, w_tag1_d;

    logic             r_v2_q, w_v2_d;
    logic [KW-1:0]    r_k2_q, w_k2_d;
    logic [Q-1:0]     r_f2_q, w_f2_d;
    logic             r_zero2_q, w_zero2_d;
    logic             r_sign2_q, w_sign2_d;
    logic [TAG_W-1:0] r_tag2_q, w_tag2_d;

    logic             r_v3_q, w_v3_d;
    logic [PW-1:0]    r_p3_q, w_p3_d;
    logic [TAG_W-1:0] r_tag3_q, w_tag3_d;

    // Datapath intermediates for S2 and S3
    logic [LW-1:0]   w_l;
    logic [PW+Q-1:0] w_shift;
    logic [PW-1:0]   w_m;
    logic [PW-1:0]   w_p;

    // A stage may load when it is empty or its successor is loading too.
    always_comb begin
        w_en3 = ~r_v3_q | out_ready;
        w_en2 = ~r_v2_q | w_en3;
        w_en1 = ~r_v1_q | w_en2;
    end

    assign in_ready = w_en1;

    // One's-complement magnitude: -1 becomes 0, which the detector maps to zero.
    always_comb begin
        w_sx = in_signed & in_x[W-1];
        w_sy = in_signed & in_y[W-1];
        w_ax = in_x ^ {W{w_sx}};
        w_ay = in_y ^ {W{w_sy}};
    end

    qlm_lod_frac #(
        .W     (W),
        .Q     (Q),
        .MIN_K (MIN_K),
        .KW    (KW)
    ) u_lod_x (
        .i_mag  (w_ax),
        .o_k    (w_kx),
        .o_frac (w_fx),
        .o_zero (w_zx)
    );

    qlm_lod_frac #(
        .W     (W),
        .Q     (Q),
        .MIN_K (MIN_K),
        .KW    (KW)
    ) u_lod_y (
        .i_mag  (w_ay),
        .o_k    (w_ky),
        .o_frac (w_fy),
        .o_zero (w_zy)
    );

    // Log add: a fraction carry rolls straight into the characteristic because
    // {k, f} is added as one fixed-point word. The sum never exceeds 2W-1 in
    // the characteristic, so LW bits hold it without overflow.
    always_comb begin
        w_l = {r_kx1_q, r_fx1_q} + {r_ky1_q, r_fy1_q};
    end

    // Antilog: restore the hidden one, shift by the characteristic and drop
    // the Q fraction bits; the wide intermediate keeps K = 2W-1 exact.
    always_comb begin
        w_shift = {{(PW-1){1'b0}}, 1'b1, r_f2_q} << r_k2_q;
        w_m     = PW'(w_shift >> Q);
        w_p     = r_zero2_q ? '0 : (w_m ^ {PW{r_sign2_q}});
    end

    // Next-state for every stage: hold when stalled, load only real data.
    always_comb begin
        w_v1_d    = r_v1_q;
        w_kx1_d   = r_kx1_q;
        w_fx1_d   = r_fx1_q;
        w_zx1_d   = r_zx1_q;
        w_ky1_d   = r_ky1_q;
        w_fy1_d   = r_fy1_q;
        w_zy1_d   = r_zy1_q;
        w_sign1_d = r_sign1_q;
        w_tag1_d  = r_tag1_q;

        w_v2_d    = r_v2_q;
        w_k2_d    = r_k2_q;
        w_f2_d    = r_f2_q;
        w_zero2_d = r_zero2_q;
        w_sign2_d = r_sign2_q;
        w_tag2_d  = r_tag2_q;

        w_v3_d    = r_v3_q;
        w_p3_d    = r_p3_q;
        w_tag3_d  = r_tag3_q;

        if (w_en1) begin
            w_v1_d = in_valid;
            if (in_valid) begin
                w_kx1_d   = w_kx;
                w_fx1_d   = w_fx;
                w_zx1_d   = w_zx;
                w_ky1_d   = w_ky;
                w_fy1_d   = w_fy;
                w_zy1_d   = w_zy;
                w_sign1_d = w_sx ^ w_sy;
                w_tag1_d  = in_tag;
            end
        end

        if (w_en2) begin
            w_v2_d = r_v1_q;
            if (r_v1_q) begin
                w_k2_d    = w_l[LW-1:Q];
                w_f2_d    = w_l[Q-1:0];
                w_zero2_d = r_zx1_q | r_zy1_q;
                w_sign2_d = r_sign1_q;
                w_tag2_d  = r_tag1_q;
            end
        end

        if (w_en3) begin
            w_v3_d = r_v2_q;
            if (r_v2_q) begin
                w_p3_d   = w_p;
                w_tag3_d = r_tag2_q;
            end
        end
    end

    // Pipeline state; reset clears every stage so nothing in flight survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1_q    <= 1'b0;
            r_kx1_q   <= '0;
            r_fx1_q   <= '0;
            r_zx1_q   <= 1'b0;
            r_ky1_q   <= '0;
            r_fy1_q   <= '0;
            r_zy1_q   <= 1'b0;
            r_sign1_q <= 1'b0;
            r_tag1_q  <= '0;
            r_v2_q    <= 1'b0;
            r_k2_q    <= '0;
            r_f2_q    <= '0;
            r_zero2_q <= 1'b0;
            r_sign2_q <= 1'b0;
            r_tag2_q  <= '0;
            r_v3_q    <= 1'b0;
            r_p3_q    <= '0;
            r_tag3_q  <= '0;
        end else begin
            r_v1_q    <= w_v1_d;
            r_kx1_q   <= w_kx1_d;
            r_fx1_q   <= w_fx1_d;
            r_zx1_q   <= w_zx1_d;
            r_ky1_q   <= w_ky1_d;
            r_fy1_q   <= w_fy1_d;
            r_zy1_q   <= w_zy1_d;
            r_sign1_q <= w_sign1_d;
            r_tag1_q  <= w_tag1_d;
            r_v2_q    <= w_v2_d;
            r_k2_q    <= w_k2_d;
            r_f2_q    <= w_f2_d;
            r_zero2_q <= w_zero2_d;
            r_sign2_q <= w_sign2_d;
            r_tag2_q  <= w_tag2_d;
            r_v3_q    <= w_v3_d;
            r_p3_q    <= w_p3_d;
            r_tag3_q  <= w_tag3_d;
        end
    end

    assign out_valid = r_v3_q;
    assign out_p     = r_p3_q;
    assign out_tag   = r_tag3_q;

endmodule : qlm_pipe_mult
`default_nettype wire

// File: tb/tb_qlm_pipe_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_qlm_pipe_mult
// Brief    : Scoreboard testbench for the pipelined quantised log multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qlm_pipe_mult;

    localparam int W     = 16;
    localparam int Q     = 5;
    localparam int MIN_K = 5;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_x;
    logic [W-1:0]     in_y;
    logic             in_signed;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_p;
    logic [TAG_W-1:0] out_tag;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [2*W-1:0]   p;
    } exp_t;

    exp_t           sb[$];
    exp_t           e;
    logic [2*W-1:0] drv_exp;
    int             n_checks = 0;
    int             n_fails  = 0;
    int             n_out    = 0;
    bit             saw_stall;
    int             out_before;

    qlm_pipe_mult #(
        .W     (W),
        .Q     (Q),
        .MIN_K (MIN_K),
        .TAG_W (TAG_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference Mitchell product computed arithmetically.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
        logic [W-1:0] a [2];
        int  k [2];
        int  f [2];
        bit  z;
        bit  sg;
        int  l, kk, ff;
        longint m;
        logic [2*W-1:0] p;
        z    = 1'b0;
        a[0] = (s && x[W-1]) ? ~x : x;
        a[1] = (s && y[W-1]) ? ~y : y;
        sg   = s && (x[W-1] ^ y[W-1]);
        for (int j = 0; j < 2; j++) begin
            k[j] = -1;
            f[j] = 0;
            for (int b = MIN_K; b < W; b++) if (a[j][b]) k[j] = b;
            if (k[j] < 0) z = 1'b1;
            else f[j] = int'(a[j] >> (k[j] - Q)) % (1 << Q);
        end
        if (z) return '0;
        l  = k[0] * (1 << Q) + f[0] + k[1] * (1 << Q) + f[1];
        kk = l / (1 << Q);
        ff = l % (1 << Q);
        m  = (longint'((1 << Q) + ff) << kk) >> Q;
        p  = m[2*W-1:0];
        return sg ? ~p : p;
    endfunction

    // Observe handshakes mid-cycle: push accepted pairs, check emitted results.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                check_eq("out_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("out_tag", 64'(out_tag), 64'(e.tag));
                    check_eq("out_p", 64'(out_p), 64'(e.p));
                end
            end
            if (in_valid && in_ready) sb.push_back('{in_tag, drv_exp});
            if (in_valid && !in_ready) saw_stall = 1'b1;
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input logic [TAG_W-1:0] t, input logic [2*W-1:0] ex);
        int guard;
        bit acc;
        guard     = 0;
        acc       = 1'b0;
        in_x      = x;
        in_y      = y;
        in_signed = s;
        in_tag    = t;
        drv_exp   = ex;
        in_valid  = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        check_eq("send_accept", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input logic [TAG_W-1:0] t);
        send(x, y, s, t, model(x, y, s));
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 300) begin
            @(posedge clk);
            g++;
        end
        #1;
        check_eq("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_signed = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        drv_exp   = '0;
        saw_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_p", 64'(out_p), 64'd0);
        check_eq("rst_out_tag", 64'(out_tag), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed products with hand-derived results.
        send(16'd64, 16'd64, 1'b0, 4'd1, 32'h0000_1000);
        send(16'd96, 16'd96, 1'b1, 4'd2, 32'h0000_2000);
        send(16'hFFA0, 16'd100, 1'b1, 4'd3, 32'hFFFF_DEFF);
        send(16'd31, 16'd1000, 1'b0, 4'd4, 32'h0);
        send(16'hFFFF, 16'd500, 1'b1, 4'd5, 32'h0);
        send(16'h0000, 16'h8000, 1'b0, 4'd6, 32'h0);
        send(16'hFFFF, 16'h0020, 1'b0, 4'd7, 32'h001F_8000);
        send(16'hFFFF, 16'hFFFF, 1'b0, 4'd8, model(16'hFFFF, 16'hFFFF, 1'b0));
        drain();

        // Backpressure in the middle of a back-to-back burst.
        saw_stall  = 1'b0;
        out_before = n_out;
        fork
            begin
                for (int t = 0; t < 6; t++)
                    send_m(16'(100 + 37 * t), 16'(2000 + 511 * t), t[0], 4'(t));
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check_eq("in_ready_fell", 64'(saw_stall), 64'd1);
        check_eq("burst_count", 64'(n_out - out_before), 64'd6);

        // Random operands under random consumer backpressure.
        fork
            begin
                for (int t = 0; t < 40; t++) begin
                    logic [W-1:0] rx, ry;
                    rx = ($urandom % 4 == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
                    ry = 16'($urandom);
                    send_m(rx, ry, 1'($urandom), 4'(t));
                end
            end
            begin
                for (int c = 0; c < 100; c++) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom % 4) != 0;
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with three transactions held in flight.
        out_ready = 1'b0;
        send_m(16'd300, 16'd400, 1'b0, 4'd10);
        send_m(16'd500, 16'd600, 1'b0, 4'd11);
        send_m(16'd700, 16'd800, 1'b0, 4'd12);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_out_p", 64'(out_p), 64'd0);
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        out_before = n_out;
        out_ready  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("no_stale_out", 64'(n_out - out_before), 64'd0);

        // Recovery after reset.
        send(16'd64, 16'd64, 1'b0, 4'd13, 32'h0000_1000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_qlm_pipe_mult
`default_nettype wire
